// File: rtl/ramio_arbiter.sv
// ramio_arbiter
//   Shares a single ramio client port between two requesters: port 0 is
//   instruction fetch, port 1 is data load/store. One transaction is in flight
//   at a time. The winning command is latched into the ram_* registers and held
//   stable until ramio completes it. Read data and a one-cycle done pulse are
//   then returned, registered, to the port that was granted. A stalled ramio
//   is aborted after TimeoutCycles WAIT cycles.
//
//   Optional feature macro: RAMIO_ARBITER_ROUND_ROBIN_EN
//     defined   -> on a tie the port not granted last time wins
//     undefined -> fixed priority, port 0 wins ties
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[1:0]                   per-port request, held until that port's done
//   read_type0/1, write_type0/1, address0/1, data_in0/1
//                              per-port command, sampled at grant
//   done[1:0]                  one-cycle completion pulse per port
//   timeout                    qualifies done: transaction aborted, rdata = 0
//   rdata                      read result, held until the next done
//   grant_id                   port owning the current/last transaction
//   ram_enable, ram_read_type, ram_write_type, ram_address, ram_data_in
//                              command to ramio
//   ram_data_out, ram_data_out_ready, ram_busy
//                              response from ramio

module ramio_arbiter #(
   parameter int AddressBitWidth = 32,
   parameter int DataBitWidth    = 32,
   parameter int TimeoutCycles   = 4096
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 req,
   input  logic [2:0]                 read_type0,
   input  logic [2:0]                 read_type1,
   input  logic [1:0]                 write_type0,
   input  logic [1:0]                 write_type1,
   input  logic [AddressBitWidth-1:0] address0,
   input  logic [AddressBitWidth-1:0] address1,
   input  logic [DataBitWidth-1:0]    data_in0,
   input  logic [DataBitWidth-1:0]    data_in1,
   output logic [1:0]                 done,
   output logic                       timeout,
   output logic [DataBitWidth-1:0]    rdata,
   output logic                       grant_id,
   output logic                       ram_enable,
   output logic [2:0]                 ram_read_type,
   output logic [1:0]                 ram_write_type,
   output logic [AddressBitWidth-1:0] ram_address,
   output logic [DataBitWidth-1:0]    ram_data_in,
   input  logic [DataBitWidth-1:0]    ram_data_out,
   input  logic                       ram_data_out_ready,
   input  logic                       ram_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // The counter only has to reach TimeoutCycles-1.
   localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntW-1:0] CntLast =
      (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

   state_t                     state_q, state_d;
   logic                       ram_enable_q, ram_enable_d;
   logic [2:0]                 ram_read_type_q, ram_read_type_d;
   logic [1:0]                 ram_write_type_q, ram_write_type_d;
   logic [AddressBitWidth-1:0] ram_address_q, ram_address_d;
   logic [DataBitWidth-1:0]    ram_data_in_q, ram_data_in_d;
   logic [1:0]                 done_q, done_d;
   logic                       timeout_q, timeout_d;
   logic [DataBitWidth-1:0]    rdata_q, rdata_d;
   logic                       grant_id_q, grant_id_d;
   logic [CntW-1:0]            cnt_q, cnt_d;

   logic                       pick;
   logic                       complete;
   logic                       timeout_hit;

   // Port selection; only meaningful when at least one req bit is set.
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
   always_comb begin
      if (req == 2'b11) pick = ~grant_id_q;
      else              pick = req[1];
   end
`else
   always_comb begin
      pick = ~req[0];
   end
`endif

   // Writes finish on !busy alone; reads (and no-ops) also need data_out_ready.
   assign complete    = !ram_busy && ((ram_write_type_q != 2'b00) || ram_data_out_ready);
   assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

   always_comb begin
      state_d          = state_q;
      ram_enable_d     = ram_enable_q;
      ram_read_type_d  = ram_read_type_q;
      ram_write_type_d = ram_write_type_q;
      ram_address_d    = ram_address_q;
      ram_data_in_d    = ram_data_in_q;
      done_d           = 2'b00;
      timeout_d        = 1'b0;
      rdata_d          = rdata_q;
      grant_id_d       = grant_id_q;
      cnt_d            = cnt_q;

      case (state_q)
         IDLE: begin
            // During a done cycle the finishing requester still shows req;
            // arbitration waits one cycle so it is not granted twice.
            if ((req != 2'b00) && (done_q == 2'b00)) begin
               grant_id_d   = pick;
               ram_enable_d = 1'b1;
               if (pick) begin
                  ram_read_type_d  = read_type1;
                  ram_write_type_d = write_type1;
                  ram_address_d    = address1;
                  ram_data_in_d    = data_in1;
               end else begin
                  ram_read_type_d  = read_type0;
                  ram_write_type_d = write_type0;
                  ram_address_d    = address0;
                  ram_data_in_d    = data_in0;
               end
               state_d = ISSUE;
            end
         end

         // Gives ramio/cache one cycle to see enable before busy is trusted.
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end

         WAIT: begin
            if (complete || timeout_hit) begin
               done_d           = grant_id_q ? 2'b10 : 2'b01;
               ram_enable_d     = 1'b0;
               ram_read_type_d  = 3'b000;
               ram_write_type_d = 2'b00;
               ram_address_d    = '0;
               ram_data_in_d    = '0;
               state_d          = IDLE;
               // A real completion wins over an abort in the same cycle.
               if (complete) begin
                  if (ram_read_type_q != 3'b000) rdata_d = ram_data_out;
               end else begin
                  timeout_d = 1'b1;
                  rdata_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d      = IDLE;
            ram_enable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         ram_enable_q     <= 1'b0;
         ram_read_type_q  <= 3'b000;
         ram_write_type_q <= 2'b00;
         ram_address_q    <= '0;
         ram_data_in_q    <= '0;
         done_q           <= 2'b00;
         timeout_q        <= 1'b0;
         rdata_q          <= '0;
         grant_id_q       <= 1'b0;
         cnt_q            <= '0;
      end else begin
         state_q          <= state_d;
         ram_enable_q     <= ram_enable_d;
         ram_read_type_q  <= ram_read_type_d;
         ram_write_type_q <= ram_write_type_d;
         ram_address_q    <= ram_address_d;
         ram_data_in_q    <= ram_data_in_d;
         done_q           <= done_d;
         timeout_q        <= timeout_d;
         rdata_q          <= rdata_d;
         grant_id_q       <= grant_id_d;
         cnt_q            <= cnt_d;
      end
   end

   assign done           = done_q;
   assign timeout        = timeout_q;
   assign rdata          = rdata_q;
   assign grant_id       = grant_id_q;
   assign ram_enable     = ram_enable_q;
   assign ram_read_type  = ram_read_type_q;
   assign ram_write_type = ram_write_type_q;
   assign ram_address    = ram_address_q;
   assign ram_data_in    = ram_data_in_q;

endmodule
